// File: rtl/sysbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_pkg
// Description : Shared Sysbus definitions for the memory responder. Holds the
//               responder FSM state encoding, the burst and line-size
//               constants, and the bit positions of the fields inside a
//               request tag {rd/wr, device[3:0], id[7:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
package sysbus_pkg;

    // Responder FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACK      = 3'd1,
        WR_DATA  = 3'd2,
        RD_WAIT  = 3'd3,
        RD_BURST = 3'd4
    } state_t;

    // Burst / line geometry: a line is BURST_LEN words of 8 bytes
    localparam int c_WORD_BYTES = 8;
    localparam int c_BURST_LEN  = 8;
    localparam int c_LINE_BYTES = c_BURST_LEN * c_WORD_BYTES;

    // Tag layout {rd/wr, device[3:0], id[7:0]}
    localparam int c_TAG_WIDTH   = 13;
    localparam int c_TAG_RW_BIT  = 12;
    localparam int c_TAG_DEV_MSB = 11;
    localparam int c_TAG_DEV_LSB = 8;

    // Field encodings
    localparam logic       c_SYSBUS_READ   = 1'b1;
    localparam logic [3:0] c_SYSBUS_MEMORY = 4'b0001;

    // Number of low byte-address bits that select a byte inside one line
    function automatic int line_offset_bits(input int burst_len);
        return $clog2(burst_len * c_WORD_BYTES);
    endfunction

endpackage : sysbus_pkg
`default_nettype wire

// File: rtl/sysbus_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_mem_array
// Description : Single-port synchronous RAM backing store. One access per
//               cycle: a write when i_we is set, otherwise a read whose data
//               appears on o_rdata after the next rising edge. The read data
//               register holds its value on cycles without a read. No reset:
//               contents survive a responder reset.
// Ports       : clk      - clock, rising edge
//               i_en     - access enable
//               i_we     - 1 = write, 0 = read (when i_en)
//               i_addr   - word address
//               i_wdata  - write data
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sysbus_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int WORDS      = 1024,
    parameter int ADDR_WIDTH = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:WORDS-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule : sysbus_mem_array
`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_mem_responder
// Description : Sysbus memory target. Accepts a request header, acks it for
//               one cycle, then either absorbs a BURST_LEN-beat write burst
//               into the backing store or, after READ_LATENCY wait cycles,
//               returns a BURST_LEN-beat read burst with per-beat
//               handshaking. Requests to other devices are acked and dropped.
// Ports       : clk          - clock, rising edge
//               reset        - asynchronous reset, active low
//               bus_reqcyc   - request / write data valid
//               bus_req      - header: byte address; data beats: write data
//               bus_reqtag   - {rd/wr, device[3:0], id[7:0]}
//               bus_reqack   - one-cycle header acknowledge
//               bus_respcyc  - read beat valid
//               bus_resp     - read beat data
//               bus_resptag  - tag of the request being answered
//               bus_respack  - initiator takes the current read beat
// Revision    : 1.0 - initial release
// ============================================================================
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = c_TAG_WIDTH,
    parameter int MEM_WORDS      = 1024,
    parameter int READ_LATENCY   = 4,
    parameter int BURST_LEN      = c_BURST_LEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int c_ADDR_W        = $clog2(MEM_WORDS);
    localparam int c_BEAT_W        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int c_LAT_W         = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    // Word-address bits inside a line (byte offset bits minus the 3 word bits)
    localparam int c_WORD_OFF_BITS = line_offset_bits(BURST_LEN) - 3;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [c_LAT_W-1:0]  c_LAST_LAT  = c_LAT_W'(READ_LATENCY - 1);
    localparam logic [c_ADDR_W-1:0] c_LINE_MASK = ~c_ADDR_W'((1 << c_WORD_OFF_BITS) - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                     r_state;
    logic [c_BEAT_W-1:0]        r_beat;
    logic [c_LAT_W-1:0]         r_lat_cnt;
    // Only the line-aligned word address of the header is kept; the byte
    // offset and the bits above the backing-store size never matter, which
    // is also what makes out-of-range addresses wrap.
    logic [c_ADDR_W-1:0]        r_word_base;
    logic [BUS_TAG_WIDTH-1:0]   r_tag;
    logic                       r_reqack;
    logic                       r_respcyc;

    state_t                     w_state_next;
    logic [c_BEAT_W-1:0]        w_beat_next;
    logic [c_BEAT_W-1:0]        w_beat_inc;
    logic [c_LAT_W-1:0]         w_lat_next;
    logic                       w_latch_hdr;
    logic                       w_tag_is_mem;
    logic                       w_tag_is_read;
    logic                       w_ram_en;
    logic                       w_ram_we;
    logic [c_ADDR_W-1:0]        w_ram_addr;
    logic [BUS_DATA_WIDTH-1:0]  w_ram_rdata;

    assign w_beat_inc    = r_beat + c_BEAT_W'(1);
    assign w_tag_is_mem  = (r_tag[c_TAG_DEV_MSB:c_TAG_DEV_LSB] == c_SYSBUS_MEMORY);
    assign w_tag_is_read = (r_tag[c_TAG_RW_BIT] == c_SYSBUS_READ);

    // ------------------------------------------------------------------
    // Next-state / RAM control
    // The RAM read for a beat is issued on the edge that makes the beat
    // current (entering RD_BURST, or accepting the previous beat), so the
    // registered RAM output already holds that beat while it is presented.
    // During a stall no read is issued and the RAM output stays put.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_lat_next   = r_lat_cnt;
        w_latch_hdr  = 1'b0;
        w_ram_en     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = r_word_base + c_ADDR_W'(r_beat);

        case (r_state)
            IDLE: begin
                if (bus_reqcyc) begin
                    w_latch_hdr  = 1'b1;
                    w_state_next = ACK;
                end
            end

            ACK: begin
                w_beat_next = '0;
                w_lat_next  = '0;
                if (!w_tag_is_mem) begin
                    w_state_next = IDLE;
                end else if (w_tag_is_read) begin
                    w_state_next = RD_WAIT;
                end else begin
                    w_state_next = WR_DATA;
                end
            end

            WR_DATA: begin
                if (bus_reqcyc) begin
                    w_ram_en = 1'b1;
                    w_ram_we = 1'b1;
                    if (r_beat == c_LAST_BEAT) begin
                        w_beat_next  = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_beat_next = w_beat_inc;
                    end
                end
            end

            RD_WAIT: begin
                if (r_lat_cnt == c_LAST_LAT) begin
                    w_state_next = RD_BURST;
                    w_beat_next  = '0;
                    w_ram_en     = 1'b1;
                    w_ram_addr   = r_word_base;
                end else begin
                    w_lat_next = r_lat_cnt + c_LAT_W'(1);
                end
            end

            RD_BURST: begin
                if (bus_respack) begin
                    if (r_beat == c_LAST_BEAT) begin
                        w_beat_next  = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_beat_next = w_beat_inc;
                        w_ram_en    = 1'b1;
                        w_ram_addr  = r_word_base + c_ADDR_W'(w_beat_inc);
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_lat_cnt   <= '0;
            r_word_base <= '0;
            r_tag       <= '0;
            r_reqack    <= 1'b0;
            r_respcyc   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_beat    <= w_beat_next;
            r_lat_cnt <= w_lat_next;
            r_reqack  <= (w_state_next == ACK);
            r_respcyc <= (w_state_next == RD_BURST);
            if (w_latch_hdr) begin
                r_word_base <= bus_req[c_ADDR_W+2:3] & c_LINE_MASK;
                r_tag       <= bus_reqtag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Backing store
    // ------------------------------------------------------------------
    sysbus_mem_array #(
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .WORDS      (MEM_WORDS),
        .ADDR_WIDTH (c_ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (bus_req),
        .o_rdata (w_ram_rdata)
    );

    // Response data/tag are forced to zero whenever no beat is valid, so an
    // asynchronous reset clears them together with bus_respcyc.
    assign bus_reqack  = r_reqack;
    assign bus_respcyc = r_respcyc;
    assign bus_resp    = r_respcyc ? w_ram_rdata : '0;
    assign bus_resptag = r_respcyc ? r_tag : '0;

endmodule : sysbus_mem_responder
`default_nettype wire

// File: tb/tb_sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysbus_mem_responder
// Description : Self-checking bench for sysbus_mem_responder. Writes drive a
//               reference memory; reads push the expected beats into a
//               scoreboard queue that is drained as the DUT presents beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysbus_mem_responder;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int WORDS = 1024;
    localparam int LAT   = 4;
    localparam int BL    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          bus_reqcyc = 1'b0;
    logic [DW-1:0] bus_req = '0;
    logic [TW-1:0] bus_reqtag = '0;
    logic          bus_respack = 1'b0;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (WORDS),
        .READ_LATENCY   (LAT),
        .BURST_LEN      (BL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } beat_t;

    beat_t         sb_q[$];
    logic [DW-1:0] model_mem [0:WORDS-1];

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int word_idx(input logic [63:0] addr, input int b);
        logic [63:0] w;
        w = ((addr >> 3) & ~(64'(BL - 1))) + 64'(b);
        return int'(w % 64'(WORDS));
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Drives a header in the current cycle (caller sits just after a rising
    // edge), waits for the ack and checks it is a single-cycle pulse arriving
    // one cycle after the header.
    task automatic send_header(input logic [63:0] addr, input logic [TW-1:0] tag, output int hdr_cyc);
        int got;
        got        = 0;
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        hdr_cyc    = cyc;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (bus_reqack) got = cyc;
        end
        check_eq("ack_seen", 128'(got != 0), 128'(1));
        if (got != 0) check_eq("ack_latency", 128'(got - hdr_cyc), 128'(1));
        @(posedge clk);
        #1;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        @(negedge clk);
        check_eq("ack_pulse", 128'(bus_reqack), 128'(0));
    endtask

    // Write burst; stall_mask[b] inserts one idle cycle before beat b.
    // Returns just after the edge that takes the last beat.
    task automatic write_burst(input logic [63:0] addr, input logic [7:0] id,
                               input logic [63:0] seed, input logic [BL-1:0] stall_mask);
        int            h;
        logic [DW-1:0] d;
        send_header(addr, {1'b0, 4'b0001, id}, h);
        for (int b = 0; b < BL; b++) begin
            if (stall_mask[b]) begin
                @(posedge clk);
                #1;
                bus_reqcyc = 1'b0;
            end
            @(posedge clk);
            #1;
            d          = seed * 64'(b + 1);
            bus_reqcyc = 1'b1;
            bus_req    = d;
            model_mem[word_idx(addr, b)] = d;
        end
        @(posedge clk);
        #1;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
    endtask

    // Read burst. mode 0: respack always 1; mode 1: respack 1,0,0,1,0,0,...
    // abort_at >= 0 asserts reset while that beat is presented.
    task automatic do_read(input logic [63:0] addr, input logic [7:0] id,
                           input int mode, input int abort_at);
        int          h;
        int          accepted;
        int          k;
        bit          first;
        bit          done;
        logic [TW-1:0] tag;
        beat_t       e;
        tag = {1'b1, 4'b0001, id};
        for (int b = 0; b < BL; b++) begin
            e.data = model_mem[word_idx(addr, b)];
            e.tag  = tag;
            sb_q.push_back(e);
        end
        send_header(addr, tag, h);
        accepted = 0;
        k        = 0;
        first    = 1'b0;
        done     = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            bus_respack = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            k++;
            @(negedge clk);
            if (bus_respcyc) begin
                if (!first) begin
                    first = 1'b1;
                    check_eq("rd_latency", 128'(cyc - h), 128'(LAT + 2));
                end
                if (abort_at >= 0 && accepted == abort_at) begin
                    reset = 1'b0;
                    #1;
                    check_eq("rst_respcyc", 128'(bus_respcyc), 128'(0));
                    check_eq("rst_resp", 128'(bus_resp), 128'(0));
                    check_eq("rst_resptag", 128'(bus_resptag), 128'(0));
                    sb_q.delete();
                    done = 1'b1;
                end else if (sb_q.size() == 0) begin
                    check_eq("extra_beat", 128'(bus_respcyc), 128'(0));
                    done = 1'b1;
                end else begin
                    check_eq("rd_data", 128'(bus_resp), 128'(sb_q[0].data));
                    check_eq("rd_tag", 128'(bus_resptag), 128'(sb_q[0].tag));
                    if (bus_respack) begin
                        void'(sb_q.pop_front());
                        accepted++;
                        if (sb_q.size() == 0) done = 1'b1;
                    end
                end
            end
        end
        if (abort_at >= 0) begin
            check_eq("abort_reached", 128'(accepted), 128'(abort_at));
            @(negedge clk);
            check_eq("rst_hold_respcyc", 128'(bus_respcyc), 128'(0));
            check_eq("rst_hold_reqack", 128'(bus_reqack), 128'(0));
            reset       = 1'b1;
            bus_respack = 1'b0;
        end else begin
            check_eq("beats", 128'(accepted), 128'(BL));
            @(negedge clk);
            check_eq("resp_end", 128'(bus_respcyc), 128'(0));
            bus_respack = 1'b0;
        end
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  h;
        bit  saw;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("reset_reqack", 128'(bus_reqack), 128'(0));
        check_eq("reset_respcyc", 128'(bus_respcyc), 128'(0));
        check_eq("reset_resp", 128'(bus_resp), 128'(0));
        check_eq("reset_resptag", 128'(bus_resptag), 128'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x11..0x88 at 0x1000 with stalls, then back-to-back read
        align();
        write_burst(64'h1000, 8'h21, 64'h11, 8'b0100_1000);
        do_read(64'h1000, 8'h31, 0, -1);

        // Stalling read
        align();
        do_read(64'h1000, 8'h32, 1, -1);

        // Second line with distinct data
        align();
        write_burst(64'h2000, 8'h22, 64'h0101_0101_0000_0003, 8'b0000_0001);

        // Unaligned and wrapped addresses
        align();
        do_read(64'h1018, 8'h33, 0, -1);
        align();
        do_read(64'(WORDS * 8 + 'h1000), 8'h34, 1, -1);

        // Reset while beat 3 is presented, then data must survive
        align();
        do_read(64'h1000, 8'h35, 0, 3);
        repeat (2) @(negedge clk);
        align();
        do_read(64'h1000, 8'h36, 0, -1);

        // Non-memory device: acked, never answered
        align();
        send_header(64'h1000, {1'b1, 4'b0011, 8'h5A}, h);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_respcyc) saw = 1'b1;
        end
        check_eq("nomem_resp", 128'(saw), 128'(0));

        // Responder back in IDLE; check the second line
        align();
        do_read(64'h2000, 8'h37, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sysbus_mem_responder
`default_nettype wire
